// File: rtl/csr_unit_pkg.sv
// Shared CSR addresses, mstatus bit positions, cause codes and address decode.
package pack;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // mstatus bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // Fixed CSR contents
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;  // MPP = 11
  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;  // RV32I
  localparam logic [31:0] IRQ_MASK      = 32'h0000_0888;  // MEIE/MTIE/MSIE

  typedef enum logic [3:0] {
    EXC_INSTR_MISALIGNED = 4'd0,
    EXC_ILLEGAL_INSTR    = 4'd2,
    EXC_BREAKPOINT       = 4'd3,
    EXC_LOAD_MISALIGNED  = 4'd4,
    EXC_STORE_MISALIGNED = 4'd6,
    EXC_ECALL_M          = 4'd11
  } exc_cause_e;

  typedef enum logic [3:0] {
    IRQ_SOFTWARE_M = 4'd3,
    IRQ_TIMER_M    = 4'd7,
    IRQ_EXTERNAL_M = 4'd11
  } irq_cause_e;

  // True when addr names an implemented CSR; high counter halves need has_hi.
  function automatic logic csr_implemented(input logic [11:0] addr, input logic has_hi);
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MHARTID:
        return 1'b1;
      CSR_MCYCLEH, CSR_MINSTRETH:
        return has_hi;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_unit_counter.sv
// Free-running counter with a 32-bit-half write port; a write replaces one half
// and holds off the increment for that cycle.
module csr_counter #(
  parameter int WIDTH     = 64,
  parameter int INC_WIDTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [INC_WIDTH-1:0] inc,
  input  logic                 write_lo,
  input  logic                 write_hi,
  input  logic [31:0]          write_data,
  output logic [WIDTH-1:0]     value
);

  logic [WIDTH-1:0] value_q, value_d, written;

  generate
    if (WIDTH > 32) begin : g_wide
      assign written = write_hi ? {write_data, value_q[31:0]}
                                : {value_q[WIDTH-1:32], write_data};
    end else begin : g_narrow
      assign written = write_data;
    end
  endgenerate

  // Next value: full-width add (carry reaches the high half at once) unless written
  always_comb begin
    // NOTE: default first so every path assigns value_d and no latch is inferred.
    value_d = value_q + {{(WIDTH-INC_WIDTH){1'b0}}, inc};
    if (write_lo || write_hi) value_d = written;
  end

  // Counter register with synchronous reset
  always_ff @(posedge clock) begin
    // NOTE: non-blocking so every flop samples pre-edge values.
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: address decode, counters, trap entry/mret, interrupts.
module csr_unit
  import pack::*;
#(
  parameter int          COUNTER_WIDTH = 64,
  parameter int          RETIRE_WIDTH  = 2,
  parameter logic [31:0] HART_ID       = 32'd0,
  parameter bit          VECTORED_EN   = 1'b1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [11:0]                         csr_read_addr,
  output logic [31:0]                         csr_read_data,
  output logic                                csr_illegal,
  input  logic                                csr_write_enable,
  input  logic [11:0]                         csr_write_addr,
  input  logic [31:0]                         csr_write_data,
  input  logic [$clog2(RETIRE_WIDTH+1)-1:0]   retire_count,
  input  logic                                trap_valid,
  input  logic                                trap_interrupt,
  input  logic [3:0]                          trap_cause,
  input  logic [31:0]                         trap_pc,
  input  logic [31:0]                         trap_value,
  input  logic                                mret,
  input  logic                                irq_external,
  input  logic                                irq_timer,
  input  logic                                irq_software,
  output logic [31:0]                         trap_vector,
  output logic [31:0]                         mepc_out,
  output logic                                irq_request
);

  localparam bit HAS_HI = (COUNTER_WIDTH == 64);

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] mip_q, mip_d;

  logic [COUNTER_WIDTH-1:0] mcycle_value, minstret_value;
  logic [31:0]              mcycle_hi, minstret_hi;
  logic                     write_ok;

  // A write lands only on an implemented, writable address and never alongside a trap
  assign write_ok = csr_write_enable && csr_implemented(csr_write_addr, HAS_HI)
                    && (csr_write_addr[11:10] != 2'b11) && !trap_valid;

  assign csr_illegal = !csr_implemented(csr_read_addr, HAS_HI)
                       || (csr_write_enable && (csr_write_addr[11:10] == 2'b11));

  csr_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_mcycle (
    .clock      (clock),
    .reset      (reset),
    .inc        (1'b1),
    .write_lo   (write_ok && (csr_write_addr == CSR_MCYCLE)),
    .write_hi   (write_ok && (csr_write_addr == CSR_MCYCLEH)),
    .write_data (csr_write_data),
    .value      (mcycle_value)
  );

  csr_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH($clog2(RETIRE_WIDTH+1))) u_minstret (
    .clock      (clock),
    .reset      (reset),
    .inc        (retire_count),
    .write_lo   (write_ok && (csr_write_addr == CSR_MINSTRET)),
    .write_hi   (write_ok && (csr_write_addr == CSR_MINSTRETH)),
    .write_data (csr_write_data),
    .value      (minstret_value)
  );

  generate
    if (HAS_HI) begin : g_hi
      assign mcycle_hi   = mcycle_value[COUNTER_WIDTH-1:32];
      assign minstret_hi = minstret_value[COUNTER_WIDTH-1:32];
    end else begin : g_no_hi
      assign mcycle_hi   = '0;
      assign minstret_hi = '0;
    end
  endgenerate

  // Next-state for CSR state: trap beats mret, mret beats an mstatus write
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mip_d          = {20'b0, irq_external, 3'b0, irq_timer, 3'b0, irq_software, 3'b0};

    if (trap_valid) begin
      mepc_d         = {trap_pc[31:2], 2'b00};
      mcause_d       = {trap_interrupt, 27'b0, trap_cause};
      mtval_d        = trap_value;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else begin
      if (mret) begin
        mstatus_mie_d  = mstatus_mpie_q;
        mstatus_mpie_d = 1'b1;
      end
      if (write_ok) begin
        case (csr_write_addr)
          CSR_MSTATUS: if (!mret) begin
            mstatus_mie_d  = csr_write_data[MSTATUS_MIE];
            mstatus_mpie_d = csr_write_data[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_d      = csr_write_data & IRQ_MASK;
          CSR_MTVEC:    mtvec_d    = {csr_write_data[31:2], 1'b0, VECTORED_EN & csr_write_data[0]};
          CSR_MSCRATCH: mscratch_d = csr_write_data;
          CSR_MEPC:     mepc_d     = {csr_write_data[31:2], 2'b00};
          CSR_MCAUSE:   mcause_d   = csr_write_data;
          CSR_MTVAL:    mtval_d    = csr_write_data;
          default: ;
        endcase
      end
    end
  end

  // CSR state registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mip_q          <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mip_q          <= mip_d;
    end
  end

  // Combinational read mux; unimplemented addresses read as zero
  always_comb begin
    csr_read_data = '0;
    case (csr_read_addr)
      CSR_MSTATUS:   csr_read_data = MSTATUS_FIXED
                                     | (32'(mstatus_mie_q)  << MSTATUS_MIE)
                                     | (32'(mstatus_mpie_q) << MSTATUS_MPIE);
      CSR_MISA:      csr_read_data = MISA_VALUE;
      CSR_MIE:       csr_read_data = mie_q;
      CSR_MTVEC:     csr_read_data = mtvec_q;
      CSR_MSCRATCH:  csr_read_data = mscratch_q;
      CSR_MEPC:      csr_read_data = mepc_q;
      CSR_MCAUSE:    csr_read_data = mcause_q;
      CSR_MTVAL:     csr_read_data = mtval_q;
      CSR_MIP:       csr_read_data = mip_q;
      CSR_MCYCLE:    csr_read_data = mcycle_value[31:0];
      CSR_MINSTRET:  csr_read_data = minstret_value[31:0];
      CSR_MCYCLEH:   csr_read_data = mcycle_hi;
      CSR_MINSTRETH: csr_read_data = minstret_hi;
      CSR_MHARTID:   csr_read_data = HART_ID;
      default:       csr_read_data = '0;
    endcase
  end

  // Handler address: vectored mode offsets interrupts by 4*cause
  always_comb begin
    trap_vector = {mtvec_q[31:2], 2'b00};
    if ((mtvec_q[1:0] == 2'b01) && trap_interrupt)
      trap_vector = {mtvec_q[31:2], 2'b00} + {26'b0, trap_cause, 2'b00};
  end

  assign mepc_out    = mepc_q;
  assign irq_request = mstatus_mie_q & (|(mip_q & mie_q));

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode CSR unit, parametrised successor of the core's fixed 16-entry CSR array. Decodes full 12-bit CSR addresses and flags illegal accesses. Keeps mcycle/minstret at configurable width with high-half access and multi-retire increments. Handles trap entry and `mret` (MIE/MPIE stacking), vectored `mtvec`, and interrupt pending/enable, raising an interrupt request to the pipeline control.

## Interface
- `COUNTER_WIDTH`, 64: mcycle/minstret width; legal values 32 or 64.
- `RETIRE_WIDTH`, 2: max instructions retired per cycle. `retire_count` width is $clog2(RETIRE_WIDTH+1).
- `HART_ID`, 0: value returned by mhartid.
- `VECTORED_EN`, 1: when 0, `mtvec` MODE is read-only 0.

Ports:
- `clock` in 1: sole clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `csr_read_addr` in 12: CSR read address.
- `csr_read_data` out 32: combinational read data; 0 when illegal.
- `csr_illegal` out 1: combinational. Asserted when the read address is unimplemented, or when `csr_write_enable` targets a read-only address (bits [11:10]==2'b11) at `csr_write_addr`.
- `csr_write_enable` in 1, `csr_write_addr` in 12, `csr_write_data` in 32: final write value (the ALU applies CSRRS/CSRRC).
- `retire_count` in clog2: instructions retired this cycle.
- `trap_valid` in 1, `trap_interrupt` in 1, `trap_cause` in 4, `trap_pc` in 32, `trap_value` in 32.
- `mret` in 1: return from trap.
- `irq_external`, `irq_timer`, `irq_software` in 1 each: level interrupt lines.
- `trap_vector` out 32: combinational handler address.
- `mepc_out` out 32: registered mepc, used as the `mret` target.
- `irq_request` out 1: registered-path interrupt request.

## Operation
- Implemented CSRs:
  - mstatus 0x300: MIE bit 3 and MPIE bit 7 writable; MPP [12:11] fixed at 11.
  - misa 0x301: read-only, 0x40000100.
  - mie 0x304: bits 11, 7, 3 writable.
  - mtvec 0x305: bit 1 forced 0.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] forced 0.
  - mcause 0x342, mtval 0x343.
  - mip 0x344: read-only view; writes ignored, not illegal.
  - mcycle 0xB00, minstret 0xB02.
  - mcycleh 0xB80, minstreth 0xB82: implemented only when COUNTER_WIDTH=64; otherwise illegal.
  - mhartid 0xF14.
- Reset values: mstatus 0x00001800, misa 0x40000100, all other state 0. Outputs after reset: `irq_request`=0, `mepc_out`=0, `trap_vector`=0.
- Counters:
  - mcycle increments by 1 each cycle.
  - minstret increments by `retire_count`, wrapping modulo 2^COUNTER_WIDTH.
  - A write to either half replaces that half only and suppresses that counter's increment for the cycle.
  - A carry from the low half into the high half happens in the same cycle as the increment.
- Trap entry (`trap_valid`):
  - mepc ← `trap_pc` & ~3.
  - mcause ← {`trap_interrupt`, 27'b0, `trap_cause`}.
  - mtval ← `trap_value`.
  - MPIE ← MIE, then MIE ← 0.
- `mret`: MIE ← MPIE, MPIE ← 1.
- Simultaneous-event priority:
  - `trap_valid` beats `mret` and any CSR write in the same cycle; the write is dropped.
  - `mret` beats a write to mstatus.
  - Counter updates always proceed.
- `trap_vector`:
  - base = mtvec & ~3.
  - If MODE=01 and `trap_interrupt`, the vector is base + 4·`trap_cause`; otherwise it is base.
- mip bits 11, 7 and 3 are registered each cycle from the external, timer and software lines respectively.
- `irq_request` = MIE & |(mip & mie).
- A write to an illegal address has no effect.

## Timing
- Reads are zero-latency combinational. Writes are visible from the next cycle (no write-to-read bypass).
- Interrupt path: interrupt line high at edge N → mip set after N → `irq_request` high in cycle N+1, provided it is enabled.
- After trap entry, MIE=0, so `irq_request` drops in the cycle after `trap_valid`.
- Reset during a pending trap or write: the reset wins, and all state returns to its reset value.

## Structure
- Package `pack` gains:
  - 12-bit CSR address localparams.
  - mstatus bit index constants (MIE=3, MPIE=7).
  - Exception/interrupt cause codes (0, 2, 3, 4, 6, 11; interrupt codes 3, 7, 11).
- Sub-module `csr_counter`:
  - Parameters: WIDTH, INC_WIDTH.
  - Inputs: `inc`, `write_lo`, `write_hi`, `write_data`.
  - Output: value.
  - Instantiated twice (mcycle, minstret).

## Test plan
- Reset, then read 0x300/0x301/0xF14 → 0x00001800 / 0x40000100 / HART_ID; `csr_illegal`=0; read 0x7C0 → `csr_illegal`=1, data 0.
- Write mcycle=0xFFFFFFFF → next cycle mcycle=0xFFFFFFFF (increment suppressed); a cycle later mcycle=0 and mcycleh=1. Apply `retire_count`=2 for 3 cycles → minstret=6.
- Set MIE=1 and mie bit 7, raise `irq_timer` at edge N → `irq_request` high cycle N+1. `trap_valid` with interrupt=1, cause 7, mtvec=0x101 → `trap_vector`=0x11C; after it, MIE=0 and MPIE=1.
- `trap_valid` (cause 2, pc 0x2003) together with a mscratch write → mepc=0x2000, mcause=2, mscratch unchanged.
- `mret` with MPIE=1 together with a mstatus write of 0 → MIE=1, MPIE=1.
- Write to 0xF14 → `csr_illegal`=1; mhartid unchanged.
